// File: rtl/matrix_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// matrix_pkg: shared size defaults and row/frame types for matrix_capture.
// Revision 1.0
// ---------------------------------------------------------------------------
package matrix_pkg;

  localparam int unsigned MATRIX_COLS = 8;
  localparam int unsigned MATRIX_ROWS = 8;

  typedef logic [MATRIX_COLS-1:0] row_t;
  typedef row_t [MATRIX_ROWS-1:0] frame_t;

  // Shift counter must hold 0..cols+1 (saturating one past a full row).
  function automatic int unsigned cnt_width(input int unsigned cols);
    return $clog2(cols + 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/edge_sync.sv
`default_nettype none
// ---------------------------------------------------------------------------
// edge_sync: multi-stage synchronizer followed by a registered rising-edge pulse.
// Revision 1.0
// ---------------------------------------------------------------------------
module edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sig_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q[0] <= sig_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule
`default_nettype wire

// File: rtl/matrix_capture.sv
`default_nettype none
// ---------------------------------------------------------------------------
// matrix_capture: snoops a shift-register LED matrix bus and rebuilds frames.
// Revision 1.0
// ---------------------------------------------------------------------------
module matrix_capture
  import matrix_pkg::*;
#(
  parameter int unsigned COLS        = MATRIX_COLS,
  parameter int unsigned ROWS        = MATRIX_ROWS,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ds,
  input  logic                 shcp,
  input  logic                 stcp,
  input  logic                 mr,
  input  logic                 oe,
  input  logic [ROWS-1:0]      rowsOut,
  output logic [ROWS*COLS-1:0] frame,
  output logic                 frame_valid,
  output logic                 row_err,
  output logic                 len_err,
  output logic                 display_on
);

  localparam int unsigned     CW       = cnt_width(COLS);
  localparam int unsigned     DW       = ROWS + 3;
  localparam logic [CW-1:0]   CNT_FULL = CW'(COLS);
  localparam logic [CW-1:0]   CNT_SAT  = CW'(COLS + 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  // Level inputs get one stage more than the strobes: the strobe pulse is
  // registered after its synchronizer, so this keeps data and edges aligned.
  logic [SYNC_STAGES:0][DW-1:0] dsync_q;
  logic                         oe_sync;
  logic                         mr_sync;
  logic                         ds_sync;
  logic [ROWS-1:0]              rows_sync;
  logic                         shcp_rise;
  logic                         stcp_rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dsync_q <= '0;
    end else begin
      dsync_q[0] <= {oe, mr, ds, rowsOut};
      for (int i = 1; i <= SYNC_STAGES; i++) begin
        dsync_q[i] <= dsync_q[i-1];
      end
    end
  end

  assign {oe_sync, mr_sync, ds_sync, rows_sync} = dsync_q[SYNC_STAGES];

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_shcp_sync (
    .clk    (clk),
    .reset  (reset),
    .sig_i  (shcp),
    .rise_o (shcp_rise)
  );

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_stcp_sync (
    .clk    (clk),
    .reset  (reset),
    .sig_i  (stcp),
    .rise_o (stcp_rise)
  );

  logic [COLS-1:0]            shift_q, shift_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [ROWS-1:0][COLS-1:0]  work_q, work_d;
  logic [ROWS-1:0]            seen_q, seen_d;
  logic [ROWS-1:0][COLS-1:0]  frame_q, frame_d;
  logic                       frame_valid_q, frame_valid_d;
  logic                       row_err_q, row_err_d;
  logic                       len_err_q, len_err_d;
  logic                       display_on_q;

  always_comb begin
    shift_d       = shift_q;
    cnt_d         = cnt_q;
    work_d        = work_q;
    seen_d        = seen_q;
    frame_d       = frame_q;
    frame_valid_d = 1'b0;
    row_err_d     = row_err_q;
    len_err_d     = len_err_q;

    if (!mr_sync) begin
      shift_d = '0;
      cnt_d   = '0;
    end else begin
      if (shcp_rise) begin
        shift_d = {shift_q[COLS-2:0], ds_sync};
      end
      if (stcp_rise) begin
        cnt_d = shcp_rise ? CNT_ONE : '0;
      end else if (shcp_rise && (cnt_q != CNT_SAT)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // The latch always sees the pre-update shift register and count.
    if (stcp_rise) begin
      if (cnt_q != CNT_FULL) begin
        len_err_d = 1'b1;
      end
      if ($onehot(rows_sync)) begin
        for (int r = 0; r < ROWS; r++) begin
          if (rows_sync[r]) begin
            work_d[r] = shift_q;
          end
        end
        seen_d = seen_q | rows_sync;
        if (&seen_d) begin
          frame_d       = work_d;
          frame_valid_d = 1'b1;
          seen_d        = '0;
        end
      end else begin
        row_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q       <= '0;
      cnt_q         <= '0;
      work_q        <= '0;
      seen_q        <= '0;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
      row_err_q     <= 1'b0;
      len_err_q     <= 1'b0;
      display_on_q  <= 1'b0;
    end else begin
      shift_q       <= shift_d;
      cnt_q         <= cnt_d;
      work_q        <= work_d;
      seen_q        <= seen_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
      row_err_q     <= row_err_d;
      len_err_q     <= len_err_d;
      display_on_q  <= ~oe_sync;
    end
  end

  assign frame       = frame_q;
  assign frame_valid = frame_valid_q;
  assign row_err     = row_err_q;
  assign len_err     = len_err_q;
  assign display_on  = display_on_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_capture.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_matrix_capture: directed bench with a frame scoreboard for matrix_capture.
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_matrix_capture;

  logic        clk;
  logic        reset;
  logic        ds;
  logic        shcp;
  logic        stcp;
  logic        mr;
  logic        oe;
  logic [7:0]  rowsOut;
  logic [63:0] frame;
  logic        frame_valid;
  logic        row_err;
  logic        len_err;
  logic        display_on;

  matrix_capture #(.COLS(8), .ROWS(8), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .ds          (ds),
    .shcp        (shcp),
    .stcp        (stcp),
    .mr          (mr),
    .oe          (oe),
    .rowsOut     (rowsOut),
    .frame       (frame),
    .frame_valid (frame_valid),
    .row_err     (row_err),
    .len_err     (len_err),
    .display_on  (display_on)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          fv_count = 0;
  int          fv0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_frame;

  // Reference model of the capture behaviour.
  logic [7:0]  m_sh;
  int          m_cnt;
  logic [63:0] m_work;
  logic [7:0]  m_seen;
  logic        m_row_err;
  logic        m_len_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_sh = '0; m_cnt = 0; m_work = '0; m_seen = '0;
    m_row_err = 1'b0; m_len_err = 1'b0;
  endtask

  task automatic m_shift(input logic b);
    m_sh = {m_sh[6:0], b};
    if (m_cnt < 9) m_cnt++;
  endtask

  task automatic m_latch(input logic [7:0] rows);
    if (m_cnt != 8) m_len_err = 1'b1;
    if ($onehot(rows)) begin
      for (int r = 0; r < 8; r++) if (rows[r]) m_work[r*8 +: 8] = m_sh;
      m_seen = m_seen | rows;
      if (m_seen == 8'hFF) begin
        exp_q.push_back(m_work);
        m_seen = '0;
      end
    end else begin
      m_row_err = 1'b1;
    end
    m_cnt = 0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_bit(input logic b);
    ds = b;
    wait_cyc(4);
    m_shift(b);
    shcp = 1'b1;
    wait_cyc(4);
    shcp = 1'b0;
    wait_cyc(2);
  endtask

  task automatic shift_bits(input logic [7:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) shift_bit(v[i]);
  endtask

  task automatic latch(input logic [7:0] rows);
    rowsOut = rows;
    wait_cyc(4);
    m_latch(rows);
    stcp = 1'b1;
    wait_cyc(4);
    stcp = 1'b0;
    wait_cyc(6);
  endtask

  task automatic mr_pulse();
    mr = 1'b0;
    wait_cyc(6);
    m_sh = '0; m_cnt = 0;
    mr = 1'b1;
    wait_cyc(6);
  endtask

  task automatic coincident(input logic b, input logic [7:0] rows);
    ds = b;
    rowsOut = rows;
    wait_cyc(4);
    m_latch(rows);
    m_shift(b);
    shcp = 1'b1;
    stcp = 1'b1;
    wait_cyc(4);
    shcp = 1'b0;
    stcp = 1'b0;
    wait_cyc(6);
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_row_err"}, {63'd0, row_err}, {63'd0, m_row_err});
    check({tag, "_len_err"}, {63'd0, len_err}, {63'd0, m_len_err});
  endtask

  // Scoreboard: every frame_valid pulse must match the oldest expected frame.
  always @(negedge clk) begin
    if (frame_valid === 1'b1) begin
      fv_count++;
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_frame_valid: observed pulse, expected none (frame %h)", frame);
      end
      if (exp_q.size() > 0) begin
        exp_frame = exp_q.pop_front();
        check("frame_data", frame, exp_frame);
      end
    end
  end

  initial begin
    reset = 1'b1; ds = 1'b0; shcp = 1'b0; stcp = 1'b0;
    mr = 1'b1; oe = 1'b0; rowsOut = '0;
    m_reset();
    wait_cyc(3);
    check("rst_frame", frame, 64'd0);
    check("rst_frame_valid", {63'd0, frame_valid}, 64'd0);
    check("rst_display_on", {63'd0, display_on}, 64'd0);
    check_flags("rst");
    reset = 1'b0;
    wait_cyc(10);
    check("display_on_enabled", {63'd0, display_on}, 64'd1);

    // Full clean scan.
    fv0 = fv_count;
    for (int r = 0; r < 8; r++) begin
      shift_bits(8'hA5 ^ 8'(r), 8);
      latch(8'(1 << r));
    end
    check("scan_fv_pulses", 64'(fv_count - fv0), 64'd1);
    check("scan_frame_hold", frame, 64'h A2A3A0A1A6A7A4A5);
    check_flags("scan");

    // Short row while the display is blanked.
    oe = 1'b1;
    wait_cyc(8);
    check("display_on_blanked", {63'd0, display_on}, 64'd0);
    fv0 = fv_count;
    shift_bits(8'h3C, 7);
    latch(8'h01);
    check_flags("short");
    for (int r = 1; r < 8; r++) begin
      shift_bits(8'h10 + 8'(r), 8);
      latch(8'(1 << r));
    end
    check("short_fv_pulses", 64'(fv_count - fv0), 64'd1);
    oe = 1'b0;

    // Multi-hot row select in the middle of a frame.
    fv0 = fv_count;
    for (int r = 0; r < 4; r++) begin
      shift_bits(8'h20 + 8'(r), 8);
      latch(8'(1 << r));
    end
    shift_bits(8'h3C, 8);
    latch(8'h03);
    check_flags("multihot");
    check("multihot_no_fv", 64'(fv_count - fv0), 64'd0);
    for (int r = 4; r < 8; r++) begin
      shift_bits(8'h20 + 8'(r), 8);
      latch(8'(1 << r));
    end
    check("multihot_fv_pulses", 64'(fv_count - fv0), 64'd1);

    // Clear via mr, then coincident shift and latch.
    fv0 = fv_count;
    shift_bits(8'hFF, 8);
    mr_pulse();
    shift_bits(8'h00, 8);
    latch(8'h01);
    shift_bits(8'h96, 8);
    coincident(1'b1, 8'h02);
    for (int r = 2; r < 8; r++) begin
      shift_bits(8'h40 + 8'(r), 8);
      latch(8'(1 << r));
    end
    check("mr_coin_fv_pulses", 64'(fv_count - fv0), 64'd1);
    check("mr_coin_row0", {56'd0, frame[7:0]}, 64'h00);
    check("mr_coin_row1", {56'd0, frame[15:8]}, 64'h96);

    // Reset mid-frame.
    for (int r = 0; r < 4; r++) begin
      shift_bits(8'h70 + 8'(r), 8);
      latch(8'(1 << r));
    end
    reset = 1'b1;
    #1;
    m_reset();
    check("midrst_frame", frame, 64'd0);
    check("midrst_frame_valid", {63'd0, frame_valid}, 64'd0);
    check("midrst_display_on", {63'd0, display_on}, 64'd0);
    check_flags("midrst");
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(10);
    fv0 = fv_count;
    for (int r = 0; r < 8; r++) begin
      shift_bits(8'h80 + 8'(r), 8);
      latch(8'(1 << r));
    end
    check("postrst_fv_pulses", 64'(fv_count - fv0), 64'd1);
    check_flags("postrst");

    wait_cyc(4);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
